vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: the VGA scan-out fetch (display) and a CPU/host port (reads and writes).
- Display has fixed priority, since a late pixel is a visible glitch. CPU traffic uses the remaining cycles under a valid/grant handshake.
- Sits between the VGA timing/pixel pipeline and the framebuffer RAM. Runs on the 25 MHz pixel clock domain.
- Pixel format is 8-bit RGB332 ({r[2:0], g[2:0], b[1:0]}).

Parameters:
- AW, 17, framebuffer address width (320x240 = 76800 words).
- DW, 8, pixel data width (RGB332).
- STARVE_LIMIT, 64, consecutive denied CPU cycles before starvation is flagged or acted on.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display fetch request for this cycle.
- disp_addr  in  AW  display fetch address.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DW  display read data.
- disp_drop  out  1  pulse: display request in this cycle was not serviced.
- cpu_req  in  1  CPU request valid; held with addr/we/wdata until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  combinational: CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DW  CPU read data.
- cpu_starved  out  1  wait counter has reached STARVE_LIMIT.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All registered outputs go to 0: ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid, disp_rdata, cpu_rvalid, cpu_rdata, cpu_starved.
  - Wait counter clears; owner pipeline clears.
  - In-flight reads are discarded; no rvalid is issued after reset.
  - cpu_gnt and disp_drop are forced to 0 while rst=1.
- Arbitration decision, cycle N, combinational:
  - If disp_req=1: display wins.
  - Else if cpu_req=1: CPU wins, cpu_gnt=1.
  - Else: idle.
  - Simultaneous requests go to display (exception: FB_STARVE_EN).
- Issue:
  - Winner's addr/we/wdata are registered onto the ram_* outputs at N+1. ram_en=1 only in issue cycles.
  - Display always issues a read (ram_we=0).
- Read return:
  - A 2-stage owner tag pipeline (DISP, CPU_RD, NONE) follows each issue.
  - ram_rdata is registered to the owner's rdata with a 1-cycle rvalid pulse at N+2.
  - Read latency from acceptance is exactly 2 cycles. A write produces no rvalid.
- Throughput: one access per cycle; back-to-back grants allowed with no bubble.
- Ordering: CPU read-after-write to the same address, granted in consecutive cycles, returns the new data (RAM is write-first at the port).
- CPU handshake:
  - Request is consumed only in a cycle with cpu_gnt=1.
  - Dropping cpu_req before grant is legal; nothing is issued.
- Wait counter:
  - Increments when cpu_req=1 and cpu_gnt=0.
  - Clears on grant or when cpu_req=0.
  - Saturates at STARVE_LIMIT.
  - cpu_starved = (count == STARVE_LIMIT), registered.
- Reset mid-operation: pending grants are lost; the CPU must re-present its request.

Optional Feature:
- Macro: VGA_FB_STARVE_EN.
- Defined:
  - When cpu_starved=1 and both requesters are active, the CPU wins one cycle.
  - In that cycle disp_drop=1 and no display rvalid is issued for it.
  - The counter clears on that grant.
- Undefined:
  - Display priority is absolute and disp_drop is tied 0.
  - cpu_starved is a status output only.

Decomposition:
- Shared package vga_pkg holds:
  - constants FB_AW=17, FB_DW=8, H_ACTIVE=640, V_ACTIVE=480;
  - owner enum typedef fb_owner_t {OWN_NONE, OWN_DISP, OWN_CPU_RD};
  - RGB332 field slice constants.
- One sub-module, fb_rd_return: the 2-stage owner tag pipeline and rdata steering.

Test Plan:
- Reset check: assert rst for 3 cycles with both requests high -> cpu_gnt=0, ram_en=0, every output 0; first grant comes 1 cycle after rst drops.
- CPU only:
  - Write addr 0x00010 data 0xE3 -> cpu_gnt in the same cycle; ram_we=1, ram_addr=0x00010 next cycle.
  - Then read 0x00010 -> cpu_rvalid 2 cycles after grant with cpu_rdata=0xE3.
- Contention:
  - disp_req held 10 cycles with cpu_req held -> cpu_gnt=0 for all 10; 10 disp_rvalid pulses in order of addresses.
  - disp_req then drops -> cpu_gnt=1 in the same cycle.
- Back-to-back: alternate disp/cpu reads every cycle to addresses 0..7 -> rdata is steered to the correct owner each cycle, no bubbles, no cross-delivery.
- Starvation with macro undefined: disp_req held 70 cycles, cpu_req high -> cpu_starved rises after 64 denied cycles, no grant, disp_drop=0.
- Starvation with VGA_FB_STARVE_EN: same stimulus -> CPU granted on the cycle after cpu_starved=1; disp_drop pulses once; counter clears; display resumes with no further drops.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA framebuffer path.
// Holds the framebuffer geometry, the read-return owner tag used by the
// arbiter, the RGB332 field positions and a small owner-selection helper.
package vga_pkg;

   // Framebuffer geometry: 320x240 words of one RGB332 pixel each
   localparam int FB_AW    = 17;
   localparam int FB_DW    = 8;

   // Visible raster of the 640x480 timing that scans the framebuffer out
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // RGB332 pixel layout: {r[2:0], g[2:0], b[1:0]}
   localparam int RGB_R_HI = 7;
   localparam int RGB_R_LO = 5;
   localparam int RGB_G_HI = 4;
   localparam int RGB_G_LO = 2;
   localparam int RGB_B_HI = 1;
   localparam int RGB_B_LO = 0;

   // Who a RAM read in flight belongs to; writes and idle cycles carry OWN_NONE
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_DISP   = 2'd1,
      OWN_CPU_RD = 2'd2
   } fb_owner_t;

   // Owner tag for the access issued this cycle. Only reads get a tag,
   // because only reads produce returning data.
   function automatic fb_owner_t issue_owner(input logic disp_win,
                                             input logic cpu_win,
                                             input logic cpu_we);
      fb_owner_t own;
      own = OWN_NONE;
      if (disp_win) begin
         own = OWN_DISP;
      end else if (cpu_win && !cpu_we) begin
         own = OWN_CPU_RD;
      end
      return own;
   endfunction

   // Pack an RGB332 pixel from its three fields
   function automatic logic [FB_DW-1:0] rgb332(input logic [2:0] r,
                                               input logic [2:0] g,
                                               input logic [1:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/fb_rd_return.sv
// fb_rd_return: read-return side of the framebuffer arbiter.
// A two-stage owner tag pipeline follows every issued access. Stage 1 lines
// up with the cycle the RAM sees ram_en; stage 2 lines up with the cycle the
// RAM drives its read data. In that cycle the data is steered to exactly one
// owner together with a one-cycle rvalid pulse. The rdata output of a
// requester that is not being served is held at zero so a consumer that
// ignores rvalid can never see another requester's pixel.
module fb_rd_return
   import vga_pkg::*;
#(
   parameter int DW = FB_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    i_issue_own,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_disp_rvalid,
   output logic [DW-1:0] o_disp_rdata,
   output logic          o_cpu_rvalid,
   output logic [DW-1:0] o_cpu_rdata
);

   fb_owner_t r_own_s1;
   fb_owner_t r_own_s2;
   fb_owner_t w_issue_own;

   assign w_issue_own = fb_owner_t'(i_issue_own);

   // Owner tag pipeline; reset empties it so no read in flight returns
   always_ff @(posedge clk) begin
      if (rst) begin
         r_own_s1 <= OWN_NONE;
         r_own_s2 <= OWN_NONE;
      end else begin
         r_own_s1 <= w_issue_own;
         r_own_s2 <= r_own_s1;
      end
   end

   // Steer the RAM read data to the owner of the stage-2 tag
   always_comb begin
      o_disp_rvalid = 1'b0;
      o_disp_rdata  = '0;
      o_cpu_rvalid  = 1'b0;
      o_cpu_rdata   = '0;
      case (r_own_s2)
         OWN_DISP: begin
            o_disp_rvalid = 1'b1;
            o_disp_rdata  = i_ram_rdata;
         end
         OWN_CPU_RD: begin
            o_cpu_rvalid = 1'b1;
            o_cpu_rdata  = i_ram_rdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA
// scan-out fetch and a CPU/host port, on the 25 MHz pixel clock.
//
// Build option: VGA_FB_STARVE_EN. When defined, a CPU that has waited
// STARVE_LIMIT cycles takes one cycle from the display while both are
// requesting; that display request is reported on disp_drop. When undefined,
// display priority is absolute, disp_drop is always 0 and cpu_starved is a
// status flag only.
//
// Handshake: the CPU presents cpu_req together with cpu_we/cpu_addr/cpu_wdata
// and holds them until cpu_gnt=1 in the same cycle; the request is consumed
// only in a cycle with cpu_gnt=1 and may be withdrawn before that. The display
// has no back-pressure: disp_req asks for this cycle only and is either
// issued or flagged with disp_drop.
//
// Timing, for an access accepted in cycle N: ram_* carry it in N+1, the RAM
// returns read data in N+2 and the owner's rvalid pulses in N+2.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int AW           = FB_AW,
   parameter int DW           = FB_DW,
   parameter int STARVE_LIMIT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_rvalid,
   output logic [DW-1:0] disp_rdata,
   output logic          disp_drop,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_starved,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   // Wait counter wide enough to hold STARVE_LIMIT itself
   localparam int             CW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT_CNT = CW'(STARVE_LIMIT);

   logic          w_override;
   logic          w_disp_win;
   logic          w_cpu_win;
   fb_owner_t     w_issue_own;
   logic [CW-1:0] w_cnt_nxt;

   logic [CW-1:0] r_wait_cnt;
   logic          r_cpu_starved;

   // Starvation override: a starved CPU beats a simultaneous display request
   always_comb begin
      w_override = 1'b0;
`ifdef VGA_FB_STARVE_EN
      w_override = r_cpu_starved & disp_req & cpu_req;
`endif
   end

   // Winner of this cycle; nobody wins while reset is asserted
   always_comb begin
      w_disp_win = 1'b0;
      w_cpu_win  = 1'b0;
      if (!rst) begin
         if (w_override) begin
            w_cpu_win = 1'b1;
         end else if (disp_req) begin
            w_disp_win = 1'b1;
         end else if (cpu_req) begin
            w_cpu_win = 1'b1;
         end
      end
   end

   assign cpu_gnt     = w_cpu_win;
   assign w_issue_own = issue_owner(w_disp_win, w_cpu_win, cpu_we);

`ifdef VGA_FB_STARVE_EN
   assign disp_drop = w_override & ~rst;
`else
   assign disp_drop = 1'b0;
`endif

   // Next wait count: counts denied CPU cycles, saturating at the limit
   always_comb begin
      w_cnt_nxt = r_wait_cnt;
      if (!cpu_req || w_cpu_win) begin
         w_cnt_nxt = '0;
      end else if (r_wait_cnt != LIMIT_CNT) begin
         w_cnt_nxt = r_wait_cnt + 1'b1;
      end
   end

   // Wait counter and registered starvation flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt    <= '0;
         r_cpu_starved <= 1'b0;
      end else begin
         r_wait_cnt    <= w_cnt_nxt;
         r_cpu_starved <= (w_cnt_nxt == LIMIT_CNT);
      end
   end

   assign cpu_starved = r_cpu_starved;

   // Issue register: the winner's access drives the RAM port one cycle later.
   // Address and write data hold their last value in idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_en <= w_disp_win | w_cpu_win;
         ram_we <= w_cpu_win & cpu_we;
         if (w_cpu_win) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
         end else if (w_disp_win) begin
            ram_addr <= disp_addr;
         end
      end
   end

   // Read return: owner tag pipeline and rdata steering
   fb_rd_return #(
      .DW (DW)
   ) u_rd_return (
      .clk           (clk),
      .rst           (rst),
      .i_issue_own   (w_issue_own),
      .i_ram_rdata   (ram_rdata),
      .o_disp_rvalid (disp_rvalid),
      .o_disp_rdata  (disp_rdata),
      .o_cpu_rvalid  (cpu_rvalid),
      .o_cpu_rdata   (cpu_rdata)
   );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter with a behavioural
// single-port write-first RAM. Inputs change 1 ns after each rising edge and
// outputs are sampled 2 ns after it. Expected RAM contents: every word starts
// as fb_init(addr); the bench knows every word it writes.
// Follows VGA_FB_STARVE_EN for the starvation expectations.
module tb_vga_fb_arbiter;
   import vga_pkg::*;

   localparam int AW = FB_AW;
   localparam int DW = FB_DW;

`ifdef VGA_FB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_rvalid;
   logic [DW-1:0] disp_rdata;
   logic          disp_drop;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_starved;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_d;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_fb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(64)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
      .disp_rdata(disp_rdata), .disp_drop(disp_drop),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .cpu_starved(cpu_starved),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [DW-1:0] fb_init(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // Behavioural single-port RAM, write-first, one-cycle read latency
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            ram_rdata <= ram_wdata;
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      disp_req  = 1'b0;
      disp_addr = '0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; disp_req = 1'b1; disp_addr = 17'h00100;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00020; cpu_wdata = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         next_cycle; #1;
         n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt c%0d got=%b exp=0", i, cpu_gnt); end
         n_checks++; if (disp_drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop c%0d got=%b exp=0", i, disp_drop); end
         n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en c%0d got=%b exp=0", i, ram_en); end
         n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we c%0d got=%b exp=0", i, ram_we); end
         n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_ram_addr c%0d got=%h exp=0", i, ram_addr); end
         n_checks++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL rst_ram_wdata c%0d got=%h exp=0", i, ram_wdata); end
         n_checks++; if (disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_disp_rvalid c%0d got=%b exp=0", i, disp_rvalid); end
         n_checks++; if (disp_rdata !== '0) begin n_fail++; $display("FAIL rst_disp_rdata c%0d got=%h exp=0", i, disp_rdata); end
         n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rvalid c%0d got=%b exp=0", i, cpu_rvalid); end
         n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_cpu_rdata c%0d got=%h exp=0", i, cpu_rdata); end
         n_checks++; if (cpu_starved !== 1'b0) begin n_fail++; $display("FAIL rst_starved c%0d got=%b exp=0", i, cpu_starved); end
      end
      // First cycle out of reset: both request, display wins
      next_cycle; rst = 1'b0; cpu_we = 1'b0; #1;
      n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL post_rst_gnt got=%b exp=0", cpu_gnt); end
      n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL post_rst_ram_en got=%b exp=0", ram_en); end
      // Display issued; CPU now alone and granted
      next_cycle; disp_req = 1'b0; #1;
      n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL first_issue_en got=%b exp=1", ram_en); end
      n_checks++; if (ram_addr !== 17'h00100) begin n_fail++; $display("FAIL first_issue_addr got=%h exp=00100", ram_addr); end
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL first_issue_we got=%b exp=0", ram_we); end
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL first_cpu_gnt got=%b exp=1", cpu_gnt); end
      next_cycle; cpu_req = 1'b0; #1;
      n_checks++; if (disp_rvalid !== 1'b1) begin n_fail++; $display("FAIL first_disp_rvalid got=%b exp=1", disp_rvalid); end
      n_checks++; if (disp_rdata !== fb_init(17'h00100)) begin n_fail++; $display("FAIL first_disp_rdata got=%h exp=%h", disp_rdata, fb_init(17'h00100)); end
      n_checks++; if (ram_addr !== 17'h00020) begin n_fail++; $display("FAIL cpu_issue_addr got=%h exp=00020", ram_addr); end
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_rvalid_early got=%b exp=0", cpu_rvalid); end
      next_cycle; #1;
      n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL first_cpu_rvalid got=%b exp=1", cpu_rvalid); end
      n_checks++; if (cpu_rdata !== fb_init(17'h00020)) begin n_fail++; $display("FAIL first_cpu_rdata got=%h exp=%h", cpu_rdata, fb_init(17'h00020)); end
      n_checks++; if (disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL disp_rvalid_extra got=%b exp=0", disp_rvalid); end
      n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL idle_ram_en got=%b exp=0", ram_en); end
   endtask

   task automatic test_cpu_only;
      next_cycle; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00010; cpu_wdata = 8'hE3; #1;
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got=%b exp=1", cpu_gnt); end
      // Read the same address in the very next cycle
      next_cycle; cpu_we = 1'b0; #1;
      n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL wr_ram_en got=%b exp=1", ram_en); end
      n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_ram_we got=%b exp=1", ram_we); end
      n_checks++; if (ram_addr !== 17'h00010) begin n_fail++; $display("FAIL wr_ram_addr got=%h exp=00010", ram_addr); end
      n_checks++; if (ram_wdata !== 8'hE3) begin n_fail++; $display("FAIL wr_ram_wdata got=%h exp=e3", ram_wdata); end
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got=%b exp=1", cpu_gnt); end
      next_cycle; cpu_req = 1'b0; #1;
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_ram_we got=%b exp=0", ram_we); end
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got=%b exp=0", cpu_rvalid); end
      next_cycle; #1;
      n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL raw_rvalid got=%b exp=1", cpu_rvalid); end
      n_checks++; if (cpu_rdata !== 8'hE3) begin n_fail++; $display("FAIL raw_rdata got=%h exp=e3", cpu_rdata); end
      next_cycle; #1;
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got=%b exp=0", cpu_rvalid); end
   endtask

   task automatic test_contention;
      exp_q.delete();
      n_pulses = 0;
      for (int k = 0; k < 13; k++) begin
         next_cycle;
         if (k < 10) begin
            disp_req = 1'b1; disp_addr = 17'h00200 + 17'(k);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00030;
         end else if (k == 10) begin
            disp_req = 1'b0;
         end else begin
            cpu_req = 1'b0;
         end
         #1;
         if (k < 10) exp_q.push_back(fb_init(17'h00200 + 17'(k)));
         n_checks++; if (cpu_gnt !== (k == 10)) begin n_fail++; $display("FAIL cont_gnt c%0d got=%b exp=%b", k, cpu_gnt, (k == 10)); end
         n_checks++; if (disp_drop !== 1'b0) begin n_fail++; $display("FAIL cont_drop c%0d got=%b exp=0", k, disp_drop); end
         n_checks++; if (cpu_rvalid !== (k == 12)) begin n_fail++; $display("FAIL cont_cpu_rvalid c%0d got=%b exp=%b", k, cpu_rvalid, (k == 12)); end
         if (disp_rvalid === 1'b1) begin
            n_pulses++;
            exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (disp_rdata !== exp_d) begin n_fail++; $display("FAIL cont_disp_rdata c%0d got=%h exp=%h", k, disp_rdata, exp_d); end
         end
         if (cpu_rvalid === 1'b1) begin
            n_checks++; if (cpu_rdata !== fb_init(17'h00030)) begin n_fail++; $display("FAIL cont_cpu_rdata got=%h exp=%h", cpu_rdata, fb_init(17'h00030)); end
         end
      end
      n_checks++; if (n_pulses != 10) begin n_fail++; $display("FAIL cont_pulses got=%0d exp=10", n_pulses); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_left got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      int j;
      for (int c = 0; c < 10; c++) begin
         next_cycle;
         if (c < 8) begin
            disp_req = (c % 2 == 0); cpu_req = (c % 2 == 1); cpu_we = 1'b0;
            disp_addr = AW'(c); cpu_addr = AW'(c);
         end else begin
            disp_req = 1'b0; cpu_req = 1'b0;
         end
         #1;
         n_checks++; if (cpu_gnt !== (c < 8 && c % 2 == 1)) begin n_fail++; $display("FAIL b2b_gnt c%0d got=%b", c, cpu_gnt); end
         if (c >= 1 && c <= 8) begin
            n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble c%0d got=%b exp=1", c, ram_en); end
            n_checks++; if (ram_addr !== AW'(c - 1)) begin n_fail++; $display("FAIL b2b_addr c%0d got=%h exp=%h", c, ram_addr, AW'(c - 1)); end
         end
         if (c >= 2) begin
            j = c - 2;
            n_checks++; if (disp_rvalid !== (j % 2 == 0)) begin n_fail++; $display("FAIL b2b_disp_rvalid c%0d got=%b", c, disp_rvalid); end
            n_checks++; if (cpu_rvalid !== (j % 2 == 1)) begin n_fail++; $display("FAIL b2b_cpu_rvalid c%0d got=%b", c, cpu_rvalid); end
            if (j % 2 == 0) begin
               n_checks++; if (disp_rdata !== fb_init(AW'(j))) begin n_fail++; $display("FAIL b2b_disp_rdata c%0d got=%h exp=%h", c, disp_rdata, fb_init(AW'(j))); end
            end else begin
               n_checks++; if (cpu_rdata !== fb_init(AW'(j))) begin n_fail++; $display("FAIL b2b_cpu_rdata c%0d got=%h exp=%h", c, cpu_rdata, fb_init(AW'(j))); end
            end
         end
      end
   endtask

   task automatic test_drop_before_grant;
      next_cycle; disp_req = 1'b1; disp_addr = 17'h00050;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00060; cpu_wdata = 8'h11; #1;
      n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL wd_gnt got=%b exp=0", cpu_gnt); end
      next_cycle; disp_req = 1'b0; cpu_req = 1'b0; #1;
      n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL wd_gnt2 got=%b exp=0", cpu_gnt); end
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wd_disp_we got=%b exp=0", ram_we); end
      next_cycle; #1;
      n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL wd_no_issue got=%b exp=0", ram_en); end
      n_checks++; if (disp_rvalid !== 1'b1) begin n_fail++; $display("FAIL wd_disp_rvalid got=%b exp=1", disp_rvalid); end
      n_checks++; if (disp_rdata !== fb_init(17'h00050)) begin n_fail++; $display("FAIL wd_disp_rdata got=%h exp=%h", disp_rdata, fb_init(17'h00050)); end
   endtask

   task automatic test_reset_mid_op;
      next_cycle; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00070; #1;
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt got=%b exp=1", cpu_gnt); end
      next_cycle; cpu_req = 1'b0; rst = 1'b1; #1;
      n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL mid_issue got=%b exp=1", ram_en); end
      next_cycle; rst = 1'b0; #1;
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid got=%b exp=0", cpu_rvalid); end
      n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL mid_ram_en got=%b exp=0", ram_en); end
      next_cycle; #1;
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid2 got=%b exp=0", cpu_rvalid); end
   endtask

   task automatic test_starvation;
      logic exp_gnt;
      logic exp_starved;
      logic exp_cv;
      exp_q.delete();
      n_pulses = 0;
      for (int k = 0; k < 74; k++) begin
         next_cycle;
         if (k < 70) begin
            disp_req = 1'b1; disp_addr = 17'h00300 + 17'(k);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00040;
         end else begin
            disp_req = 1'b0; cpu_req = 1'b0;
         end
         #1;
         exp_gnt     = STARVE_EN && (k == 64);
         exp_starved = STARVE_EN ? (k == 64) : (k >= 64 && k <= 70);
         exp_cv      = STARVE_EN && (k == 66);
         if (k < 70 && !exp_gnt) exp_q.push_back(fb_init(17'h00300 + 17'(k)));
         n_checks++; if (cpu_gnt !== exp_gnt) begin n_fail++; $display("FAIL stv_gnt c%0d got=%b exp=%b", k, cpu_gnt, exp_gnt); end
         n_checks++; if (cpu_starved !== exp_starved) begin n_fail++; $display("FAIL stv_starved c%0d got=%b exp=%b", k, cpu_starved, exp_starved); end
         n_checks++; if (disp_drop !== exp_gnt) begin n_fail++; $display("FAIL stv_drop c%0d got=%b exp=%b", k, disp_drop, exp_gnt); end
         n_checks++; if (cpu_rvalid !== exp_cv) begin n_fail++; $display("FAIL stv_cpu_rvalid c%0d got=%b exp=%b", k, cpu_rvalid, exp_cv); end
         if (cpu_rvalid === 1'b1) begin
            n_checks++; if (cpu_rdata !== fb_init(17'h00040)) begin n_fail++; $display("FAIL stv_cpu_rdata got=%h exp=%h", cpu_rdata, fb_init(17'h00040)); end
         end
         if (disp_rvalid === 1'b1) begin
            n_pulses++;
            exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (disp_rdata !== exp_d) begin n_fail++; $display("FAIL stv_disp_rdata c%0d got=%h exp=%h", k, disp_rdata, exp_d); end
         end
      end
      n_checks++; if (n_pulses != (STARVE_EN ? 69 : 70)) begin n_fail++; $display("FAIL stv_pulses got=%0d exp=%0d", n_pulses, (STARVE_EN ? 69 : 70)); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stv_left got=%0d exp=0", exp_q.size()); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = fb_init(AW'(i));
      idle_inputs;
      rst = 1'b1;
      test_reset;
      test_cpu_only;
      test_contention;
      test_back_to_back;
      test_drop_before_grant;
      test_reset_mid_op;
      test_starvation;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
